buffer_port_arbiter: RTL and testbench

- Shares one 2048x8 simple dual-port block RAM (one registered read port, one write port, both on Clk) between two requesters.
  - Requester A is the cartridge CPU bus.
  - Requester B is the SPI transfer engine.
- Read and write ports are arbitrated independently, round-robin.
- B may lock the buffer for bursts; a bounded lock length prevents A starvation.
- Same-cycle read/write to one address forwards the new data (write-first).

---
 rtl/buffer_arb_pkg.sv | 6 +
 rtl/rr_arbiter2.sv | 24 ++
 rtl/buffer_port_arbiter.sv | 113 +++++++++++
 tb/tb_buffer_port_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/buffer_arb_pkg.sv
// buffer_arb_pkg: shared types and defaults for the buffer port arbiter
package buffer_arb_pkg;
  localparam int ADDR_WIDTH_DEF = 11;
  typedef enum logic {REQ_A, REQ_B} requester_t;
  typedef enum logic [1:0] {LOCK_IDLE, LOCK_LOCKED, LOCK_YIELD} lock_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter with per-requester masks
module rr_arbiter2
  import buffer_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);
  logic [1:0] elig;
  requester_t last_q, last_d;
  // grant the sole eligible requester, or the one that did not win last time
  always_comb begin
    elig = req_i & ~mask_i;
    gnt_o = &elig ? (last_q == REQ_B ? 2'b01 : 2'b10) : elig;
    last_d = gnt_o[0] ? REQ_A : gnt_o[1] ? REQ_B : last_q;
  end
  // last winner starts as B so A wins the first contention
  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_B;
    else last_q <= last_d;
  end
endmodule

// File: rtl/buffer_port_arbiter.sv
// buffer_port_arbiter: shares one byte RAM between the CPU bus (A) and SPI engine (B)
module buffer_port_arbiter
  import buffer_arb_pkg::*;
#(
  parameter int AddrWidth     = ADDR_WIDTH_DEF,
  parameter int LockMaxCycles = 64
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 RdReqA,
  input  logic                 RdReqB,
  input  logic [AddrWidth-1:0] RdAddrA,
  input  logic [AddrWidth-1:0] RdAddrB,
  output logic                 RdAckA,
  output logic                 RdAckB,
  output logic                 RdValidA,
  output logic                 RdValidB,
  output logic [7:0]           RdData,
  input  logic                 WrReqA,
  input  logic                 WrReqB,
  input  logic [AddrWidth-1:0] WrAddrA,
  input  logic [AddrWidth-1:0] WrAddrB,
  input  logic [7:0]           WrDataA,
  input  logic [7:0]           WrDataB,
  output logic                 WrAckA,
  output logic                 WrAckB,
  input  logic                 LockB,
  output logic                 LockActive
);
  localparam int CW = $clog2(LockMaxCycles);
  lock_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] rd_gnt, wr_gnt, mask, rd_valid_q;
  logic mask_a, mask_b, wr_en, rd_en, byp_q, byp_d;
  logic [AddrWidth-1:0] rd_addr, wr_addr;
  logic [7:0] wr_data, ram_q, byp_data_q;
  logic [7:0] mem_q [0:(1<<AddrWidth)-1];
  // reset masks everyone so no grant issued during reset reaches the RAM or outputs
  always_comb begin
    mask_a = state_q == LOCK_LOCKED;
    mask_b = state_q == LOCK_YIELD;
    mask = {mask_b | Reset, mask_a | Reset};
  end
  rr_arbiter2 u_rd_arb (
    .clk(Clk), .rst(Reset), .req_i({RdReqB, RdReqA}), .mask_i(mask), .gnt_o(rd_gnt)
  );
  rr_arbiter2 u_wr_arb (
    .clk(Clk), .rst(Reset), .req_i({WrReqB, WrReqA}), .mask_i(mask), .gnt_o(wr_gnt)
  );
  // route the winner's address/data to the RAM and detect same-address read/write
  always_comb begin
    rd_en = |rd_gnt;
    wr_en = |wr_gnt;
    rd_addr = rd_gnt[1] ? RdAddrB : RdAddrA;
    wr_addr = wr_gnt[1] ? WrAddrB : WrAddrA;
    wr_data = wr_gnt[1] ? WrDataB : WrDataA;
    byp_d = rd_en & wr_en & (rd_addr == wr_addr);
  end
  // RAM write port
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end
  // registered read port, write-first bypass and read-valid tracking
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ram_q <= '0;
      byp_q <= 1'b0;
      byp_data_q <= '0;
      rd_valid_q <= '0;
    end else begin
      if (rd_en) ram_q <= mem_q[rd_addr];
      byp_q <= byp_d;
      byp_data_q <= wr_data;
      rd_valid_q <= rd_gnt;
    end
  end
  // lock FSM: B bursts in LOCKED, a bounded lock forces a YIELD to A
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      LOCK_IDLE: if (LockB) begin
        state_d = LOCK_LOCKED;
        cnt_d = '0;
      end
      LOCK_LOCKED: begin
        cnt_d = cnt_q + 1'b1;
        if (!LockB) state_d = LOCK_IDLE;
        else if (cnt_q == CW'(LockMaxCycles - 1)) state_d = LOCK_YIELD;
      end
      LOCK_YIELD: if (rd_gnt[0] | wr_gnt[0] | ~(RdReqA | WrReqA)) state_d = LOCK_IDLE;
      default: state_d = LOCK_IDLE;
    endcase
  end
  // lock state registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= LOCK_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign RdAckA = rd_gnt[0];
  assign RdAckB = rd_gnt[1];
  assign WrAckA = wr_gnt[0];
  assign WrAckB = wr_gnt[1];
  assign RdValidA = rd_valid_q[0];
  assign RdValidB = rd_valid_q[1];
  assign RdData = byp_q ? byp_data_q : ram_q;
  assign LockActive = state_q == LOCK_LOCKED;
endmodule

// File: tb/tb_buffer_port_arbiter.sv
// tb_buffer_port_arbiter: directed self-checking bench for buffer_port_arbiter
module tb_buffer_port_arbiter;
  logic Clk = 1'b0;
  logic Reset;
  logic RdReqA, RdReqB, RdAckA, RdAckB, RdValidA, RdValidB;
  logic [10:0] RdAddrA, RdAddrB, WrAddrA, WrAddrB;
  logic [7:0] RdData, WrDataA, WrDataB;
  logic WrReqA, WrReqB, WrAckA, WrAckB, LockB, LockActive;
  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  buffer_port_arbiter #(.AddrWidth(11), .LockMaxCycles(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .RdReqA(RdReqA), .RdReqB(RdReqB), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdAckA(RdAckA), .RdAckB(RdAckB), .RdValidA(RdValidA), .RdValidB(RdValidB),
    .RdData(RdData),
    .WrReqA(WrReqA), .WrReqB(WrReqB), .WrAddrA(WrAddrA), .WrAddrB(WrAddrB),
    .WrDataA(WrDataA), .WrDataB(WrDataB), .WrAckA(WrAckA), .WrAckB(WrAckB),
    .LockB(LockB), .LockActive(LockActive)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_a(input logic [10:0] addr, input logic [7:0] data);
    WrReqA = 1'b1; WrAddrA = addr; WrDataA = data;
    #1 check("wr_ack_a", WrAckA, 1);
    step();
    WrReqA = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    RdReqA = 0; RdReqB = 0; RdAddrA = '0; RdAddrB = '0;
    WrReqA = 0; WrReqB = 0; WrAddrA = '0; WrAddrB = '0; WrDataA = '0; WrDataB = '0;
    LockB = 0;
    step();
    RdReqA = 1'b1;
    #1;
    check("rst_rd_ack_a", RdAckA, 0);
    check("rst_rd_valid", {RdValidB, RdValidA}, 0);
    check("rst_rd_data", RdData, 0);
    check("rst_lock", LockActive, 0);
    step();
    RdReqA = 1'b0;
    Reset = 1'b0;
    write_a(11'h010, 8'h11);
    write_a(11'h020, 8'h22);
    write_a(11'h100, 8'h00);
    write_a(11'h101, 8'h77);

    RdReqA = 1; RdAddrA = 11'h010; RdReqB = 1; RdAddrB = 11'h020;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_ack_a", RdAckA, (i % 2) == 0);
      check("alt_ack_b", RdAckB, (i % 2) == 1);
      if (i > 0) begin
        check("alt_valid_a", RdValidA, ((i - 1) % 2) == 0);
        check("alt_data", RdData, ((i - 1) % 2) == 0 ? 32'h11 : 32'h22);
      end
      step();
    end
    RdReqA = 0; RdReqB = 0;
    #1;
    check("alt_last_valid_b", RdValidB, 1);
    check("alt_last_data", RdData, 32'h22);

    write_a(11'h7FF, 8'h5A);
    RdReqB = 1; RdAddrB = 11'h7FF;
    #1 check("rb_ack_b", RdAckB, 1);
    step();
    RdReqB = 0;
    #1;
    check("rb_valid_b", RdValidB, 1);
    check("rb_valid_a", RdValidA, 0);
    check("rb_data", RdData, 32'h5A);

    WrReqB = 1; WrAddrB = 11'h100; WrDataB = 8'hC3; RdReqA = 1; RdAddrA = 11'h100;
    #1 check("byp_acks", {WrAckB, RdAckA}, 2'b11);
    step();
    WrReqB = 0; RdReqA = 0;
    #1;
    check("byp_valid_a", RdValidA, 1);
    check("byp_data", RdData, 32'hC3);
    WrReqB = 1; WrAddrB = 11'h100; WrDataB = 8'hC3; RdReqA = 1; RdAddrA = 11'h101;
    #1 check("nobyp_acks", {WrAckB, RdAckA}, 2'b11);
    step();
    WrReqB = 0; RdReqA = 0;
    #1 check("nobyp_data", RdData, 32'h77);

    RdReqA = 1; RdAddrA = 11'h010; LockB = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) RdReqB = 1;
      if (i == 6) begin LockB = 0; RdReqB = 0; end
      #1;
      check("lk_active", LockActive, i >= 1 && i <= 6);
      check("lk_ack_a", RdAckA, i == 0 || i == 7);
      if (i >= 1 && i <= 5) check("lk_ack_b", RdAckB, 1);
      step();
    end
    RdReqA = 0;
    step();

    RdReqA = 1; LockB = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("yld_active", LockActive, (i >= 1 && i <= 8) || i == 11);
      check("yld_ack_a", RdAckA, !((i >= 1 && i <= 8) || i == 11));
      step();
    end
    RdReqA = 0; LockB = 0;
    step();
    step();

    LockB = 1; RdReqA = 1;
    #1 check("mr_ack_a", RdAckA, 1);
    step();
    Reset = 1;
    #1 check("mr_locked", LockActive, 1);
    step();
    Reset = 0;
    #1;
    check("mr_valid_a", RdValidA, 0);
    check("mr_data", RdData, 0);
    check("mr_lock", LockActive, 0);
    check("mr_idle_ack_a", RdAckA, 1);
    RdReqA = 0; LockB = 0;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
